// File: rtl/cic_rate_ctrl.sv
// Run-time decimation-ratio sequencer for the variable-rate CIC decimator.
// It validates a request, waits for an output boundary, flushes, loads and masks the settling outputs.
module cic_rate_ctrl #(
  parameter int unsigned RATE_DW      = 32,
  parameter int unsigned CIC_R        = 10,
  parameter int unsigned CIC_R_MIN    = 2,
  parameter int unsigned CIC_N        = 7,
  parameter int unsigned FLUSH_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [RATE_DW-1:0] s_axis_cfg_tdata,
  input  logic               s_axis_cfg_tvalid,
  output logic               s_axis_cfg_tready,
  input  logic               cic_in_tvalid,
  input  logic               cic_out_tvalid,
  output logic               cic_reset_n,
  output logic [RATE_DW-1:0] m_axis_rate_tdata,
  output logic               m_axis_rate_tvalid,
  output logic               out_tvalid_gated,
  output logic [RATE_DW-1:0] current_rate,
  output logic               busy,
  output logic               cfg_error
);

  localparam int unsigned SW = $clog2(CIC_N + 1);
  localparam int unsigned FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [RATE_DW-1:0] RATE_MAX = RATE_DW'(CIC_R);
  localparam logic [RATE_DW-1:0] RATE_MIN = RATE_DW'(CIC_R_MIN);
  localparam logic [FW-1:0]      FLUSH_LAST  = FW'(FLUSH_CYCLES - 1);
  localparam logic [SW-1:0]      SETTLE_LAST = SW'(CIC_N - 1);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WAIT_BND,
    ST_FLUSH,
    ST_LOAD,
    ST_SETTLE
  } state_e;

  state_e             state_q, state_d;
  logic [RATE_DW-1:0] pending_q, pending_d;
  logic [RATE_DW:0]   wait_cnt_q, wait_cnt_d;
  logic [FW-1:0]      flush_cnt_q, flush_cnt_d;
  logic [SW-1:0]      settle_cnt_q, settle_cnt_d;
  logic               cfg_error_d;

  logic               cic_reset_n_q;
  logic [RATE_DW-1:0] rate_tdata_q;
  logic               rate_tvalid_q;
  logic [RATE_DW-1:0] current_rate_q;
  logic               tready_q;
  logic               busy_q;
  logic               cfg_error_q;

  logic               cfg_hs;
  logic               cfg_bad;
  logic [RATE_DW:0]   wait_inc;
  logic [RATE_DW:0]   timeout_lim;

  assign cfg_hs      = s_axis_cfg_tvalid & tready_q;
  assign cfg_bad     = (s_axis_cfg_tdata < RATE_MIN) || (s_axis_cfg_tdata > RATE_MAX);
  assign wait_inc    = wait_cnt_q + 1'b1;
  // Twice the ratio in effect: one extra bit so 2*CIC_R never wraps.
  assign timeout_lim = {current_rate_q, 1'b0};

  // NOTE: every next-state signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    wait_cnt_d   = wait_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    settle_cnt_d = settle_cnt_q;
    cfg_error_d  = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        state_d     = ST_FLUSH;
        pending_d   = RATE_MAX;
        flush_cnt_d = '0;
      end
      ST_IDLE: begin
        if (cfg_hs) begin
          if (cfg_bad) begin
            cfg_error_d = 1'b1;
          end else if (s_axis_cfg_tdata != current_rate_q) begin
            pending_d  = s_axis_cfg_tdata;
            wait_cnt_d = '0;
            state_d    = ST_WAIT_BND;
          end
        end
      end
      ST_WAIT_BND: begin
        if (cic_in_tvalid) wait_cnt_d = wait_inc;
        if (cic_out_tvalid || (cic_in_tvalid && (wait_inc == timeout_lim))) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = '0;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == FLUSH_LAST) state_d = ST_LOAD;
        else                           flush_cnt_d = flush_cnt_q + 1'b1;
      end
      ST_LOAD: begin
        state_d      = ST_SETTLE;
        settle_cnt_d = '0;
      end
      ST_SETTLE: begin
        if (cic_out_tvalid) begin
          if (settle_cnt_q == SETTLE_LAST) state_d = ST_IDLE;
          else                             settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_INIT;
      pending_q      <= RATE_MAX;
      wait_cnt_q     <= '0;
      flush_cnt_q    <= '0;
      settle_cnt_q   <= '0;
      cic_reset_n_q  <= 1'b0;
      rate_tdata_q   <= RATE_MAX;
      rate_tvalid_q  <= 1'b0;
      current_rate_q <= RATE_MAX;
      tready_q       <= 1'b0;
      busy_q         <= 1'b1;
      cfg_error_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      wait_cnt_q    <= wait_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      settle_cnt_q  <= settle_cnt_d;
      // Outputs are decoded from the next state so they line up with the state they describe.
      cic_reset_n_q <= !((state_d == ST_INIT) || (state_d == ST_FLUSH));
      rate_tvalid_q <= (state_d == ST_LOAD);
      tready_q      <= (state_d == ST_IDLE);
      busy_q        <= (state_d != ST_IDLE);
      cfg_error_q   <= cfg_error_d;
      if (state_d == ST_LOAD) begin
        rate_tdata_q   <= pending_d;
        current_rate_q <= pending_d;
      end
    end
  end

  assign s_axis_cfg_tready  = tready_q;
  assign cic_reset_n        = cic_reset_n_q;
  assign m_axis_rate_tdata  = rate_tdata_q;
  assign m_axis_rate_tvalid = rate_tvalid_q;
  assign current_rate       = current_rate_q;
  assign busy               = busy_q;
  assign cfg_error          = cfg_error_q;
  assign out_tvalid_gated   = cic_out_tvalid & (state_q == ST_IDLE);

endmodule

// File: tb/tb_cic_rate_ctrl.sv
// Directed bench for cic_rate_ctrl with default parameters (CIC_R=10, CIC_N=7, FLUSH_CYCLES=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_cic_rate_ctrl;

  localparam int RATE_DW = 32;

  logic               clk;
  logic               reset;
  logic [RATE_DW-1:0] cfg_tdata;
  logic               cfg_tvalid;
  logic               cfg_tready;
  logic               in_tv;
  logic               out_tv;
  logic               cic_reset_n;
  logic [RATE_DW-1:0] rate_tdata;
  logic               rate_tvalid;
  logic               gated;
  logic [RATE_DW-1:0] current_rate;
  logic               busy;
  logic               cfg_error;

  int n_checks = 0;
  int n_errors = 0;

  cic_rate_ctrl dut (
    .clk                (clk),
    .reset              (reset),
    .s_axis_cfg_tdata   (cfg_tdata),
    .s_axis_cfg_tvalid  (cfg_tvalid),
    .s_axis_cfg_tready  (cfg_tready),
    .cic_in_tvalid      (in_tv),
    .cic_out_tvalid     (out_tv),
    .cic_reset_n        (cic_reset_n),
    .m_axis_rate_tdata  (rate_tdata),
    .m_axis_rate_tvalid (rate_tvalid),
    .out_tvalid_gated   (gated),
    .current_rate       (current_rate),
    .busy               (busy),
    .cfg_error          (cfg_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [RATE_DW-1:0] v);
    cfg_tdata  = v;
    cfg_tvalid = 1'b1;
    @(negedge clk);
    cfg_tvalid = 1'b0;
  endtask

  // Waits for the load strobe, counting further low cic_reset_n samples on the way.
  task automatic wait_load(input string tag, input int exp_rate, input int exp_low);
    int low = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rate_tvalid) begin
        seen = 1'b1;
        break;
      end
      if (!cic_reset_n) low++;
    end
    check({tag, "_load_seen"}, seen, 1);
    check({tag, "_flush_low"}, low, exp_low);
    check({tag, "_load_data"}, rate_tdata, exp_rate);
    check({tag, "_cur_rate"}, current_rate, exp_rate);
    check({tag, "_rstn_hi"}, cic_reset_n, 1);
  endtask

  // Called at the LOAD sample: seven masked outputs, then the eighth passes.
  task automatic settle(input string tag);
    @(negedge clk);
    check({tag, "_strobe_1cyc"}, rate_tvalid, 0);
    check({tag, "_busy_settle"}, busy, 1);
    for (int k = 1; k <= 7; k++) begin
      out_tv = 1'b1;
      #1;
      check($sformatf("%s_mask%0d", tag, k), gated, 0);
      @(negedge clk);
      out_tv = 1'b0;
      if (k < 7) @(negedge clk);
    end
    check({tag, "_busy_idle"}, busy, 0);
    check({tag, "_tready_idle"}, cfg_tready, 1);
    out_tv = 1'b1;
    #1;
    check({tag, "_pass8"}, gated, 1);
    @(negedge clk);
    out_tv = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    cfg_tdata  = '0;
    cfg_tvalid = 1'b0;
    in_tv      = 1'b0;
    out_tv     = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_rstn", cic_reset_n, 0);
    check("rst_ltv", rate_tvalid, 0);
    check("rst_tready", cfg_tready, 0);
    check("rst_err", cfg_error, 0);
    check("rst_busy", busy, 1);
    check("rst_rate", current_rate, 10);
    check("rst_tdata", rate_tdata, 10);

    // Release: four low clocks, load 10, settle
    reset = 1'b0;
    wait_load("init", 10, 4);
    settle("init");

    // Request 5, decimator outputs every 10 inputs
    request(5);
    check("r5_tready_drop", cfg_tready, 0);
    check("r5_busy", busy, 1);
    for (int i = 1; i <= 10; i++) begin
      in_tv  = 1'b1;
      out_tv = (i == 10);
      @(negedge clk);
      if (i == 9)  check("r5_wait_rstn", cic_reset_n, 1);
      if (i == 10) check("r5_flush_rstn", cic_reset_n, 0);
    end
    in_tv  = 1'b0;
    out_tv = 1'b0;
    wait_load("r5", 5, 3);
    settle("r5");

    // Out-of-range requests
    request(1);
    check("lo_err_pulse", cfg_error, 1);
    check("lo_busy", busy, 0);
    check("lo_tready", cfg_tready, 1);
    @(negedge clk);
    check("lo_err_clear", cfg_error, 0);
    check("lo_rate", current_rate, 5);
    check("lo_rstn", cic_reset_n, 1);
    request(11);
    check("hi_err_pulse", cfg_error, 1);
    check("hi_busy", busy, 0);
    @(negedge clk);
    check("hi_err_clear", cfg_error, 0);
    check("hi_rate", current_rate, 5);
    check("hi_rstn", cic_reset_n, 1);

    // Stalled boundary at rate 5: timeout after 10 input strobes
    request(10);
    for (int i = 1; i <= 10; i++) begin
      in_tv = 1'b1;
      @(negedge clk);
      if (i == 9)  check("to5_wait_rstn", cic_reset_n, 1);
      if (i == 10) check("to5_flush_rstn", cic_reset_n, 0);
    end
    in_tv = 1'b0;
    wait_load("to5", 10, 3);
    settle("to5");

    // Same-rate request
    request(10);
    check("same_err", cfg_error, 0);
    check("same_busy", busy, 0);
    check("same_tready", cfg_tready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("same_rstn", cic_reset_n, 1);
      check("same_ltv", rate_tvalid, 0);
      check("same_busy_hold", busy, 0);
    end
    check("same_rate", current_rate, 10);

    // Stalled boundary at rate 10 with sparse inputs; request 7 held throughout
    request(3);
    cfg_tdata  = 7;
    cfg_tvalid = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      in_tv = 1'b1;
      @(negedge clk);
      in_tv = 1'b0;
      if (i == 19) check("to10_wait_rstn", cic_reset_n, 1);
      if (i == 20) check("to10_flush_rstn", cic_reset_n, 0);
      if (i < 20) @(negedge clk);
    end
    check("held_tready_flush", cfg_tready, 0);
    wait_load("to10", 3, 3);
    check("held_tready_load", cfg_tready, 0);
    settle("to10");
    cfg_tvalid = 1'b0;
    check("held_accepted_busy", busy, 1);
    check("held_accepted_tready", cfg_tready, 0);
    check("held_rate_before", current_rate, 3);
    in_tv  = 1'b1;
    out_tv = 1'b1;
    @(negedge clk);
    in_tv  = 1'b0;
    out_tv = 1'b0;
    check("held_flush_rstn", cic_reset_n, 0);
    wait_load("held", 7, 3);
    settle("held");

    // Reset asserted mid-SETTLE
    request(4);
    out_tv = 1'b1;
    @(negedge clk);
    out_tv = 1'b0;
    wait_load("r4", 4, 3);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      out_tv = 1'b1;
      @(negedge clk);
      out_tv = 1'b0;
      @(negedge clk);
    end
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_rate", current_rate, 10);
    check("mid_rst_rstn", cic_reset_n, 0);
    check("mid_rst_busy", busy, 1);
    check("mid_rst_tready", cfg_tready, 0);
    check("mid_rst_tdata", rate_tdata, 10);
    @(negedge clk);
    reset = 1'b0;
    wait_load("reinit", 10, 4);
    settle("reinit");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cic_rate_ctrl.md
Name: cic_rate_ctrl

Overview:
- Sequences run-time decimation-ratio changes for the variable-rate CIC decimator.
- Accepts rate requests from software/AXI-Stream, validates them, and waits for a decimator output boundary.
- Flushes the filter with its active-low reset, loads the new ratio over the filter's rate stream, then masks the transient outputs while the comb/integrator chain settles.
- Sits between the configuration source and the decimator's rate port, and gates the decimator's output valid.

Parameters:
RATE_DW, 32, rate data width (matches decimator)
CIC_R, 10, maximum decimation ratio; also the ratio loaded after reset
CIC_R_MIN, 2, minimum legal ratio
CIC_N, 7, number of stages; number of decimator outputs discarded after a load
FLUSH_CYCLES, 4, clocks cic_reset_n is held low per flush (≥1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
s_axis_cfg_tdata  in  RATE_DW  requested decimation ratio (unsigned)
s_axis_cfg_tvalid  in  1  request valid
s_axis_cfg_tready  out  1  request accepted when tvalid&tready
cic_in_tvalid  in  1  monitor: decimator input sample strobe
cic_out_tvalid  in  1  monitor: decimator output strobe
cic_reset_n  out  1  active-low reset driven to decimator
m_axis_rate_tdata  out  RATE_DW  ratio to decimator rate port
m_axis_rate_tvalid  out  1  one-cycle load strobe
out_tvalid_gated  out  1  cic_out_tvalid masked during settling
current_rate  out  RATE_DW  ratio currently in effect
busy  out  1  high in every state except IDLE
cfg_error  out  1  one-cycle pulse on rejected request

Behaviour:
- Reset (async, active-high) forces the following, whether idle or mid-sequence:
  - state=INIT, cic_reset_n=0, m_axis_rate_tvalid=0, s_axis_cfg_tready=0.
  - cfg_error=0, busy=1, current_rate=CIC_R, m_axis_rate_tdata=CIC_R, all counters 0.
- All outputs are registered except out_tvalid_gated = cic_out_tvalid & (state==IDLE), which is combinational.
- States:
  - INIT: after reset deassert, go to FLUSH with pending=CIC_R.
  - IDLE: s_axis_cfg_tready=1; this is the only state accepting requests. On handshake with value v:
    - v<CIC_R_MIN or v>CIC_R: drop; pulse cfg_error next cycle; stay in IDLE.
    - v==current_rate: accept, no action, no error.
    - otherwise: pending=v; go to WAIT_BND; tready drops the cycle after the handshake.
  - WAIT_BND:
    - On the first cic_out_tvalid seen in this state, go to FLUSH next cycle.
    - Timeout: count cic_in_tvalid strobes; when the count reaches 2*current_rate without an output, go to FLUSH.
    - If cic_out_tvalid and the timeout occur in the same cycle, take the same transition (no conflict).
  - FLUSH:
    - cic_reset_n=0 for exactly FLUSH_CYCLES clocks, with the first low cycle being the first cycle in FLUSH; then go to LOAD.
    - cic_reset_n is high in every other state except INIT.
  - LOAD (one cycle): m_axis_rate_tdata=pending and m_axis_rate_tvalid=1 in this cycle; current_rate updates to pending in the same cycle; go to SETTLE.
  - SETTLE:
    - Count cic_out_tvalid strobes; out_tvalid_gated is held 0.
    - After CIC_N strobes, go to IDLE. The CIC_N-th strobe is still masked; the first passed output is strobe CIC_N+1.
- Timing:
  - Request-to-load latency is at most boundary wait + FLUSH_CYCLES + 1 clocks.
  - Requests presented while busy are not accepted; the source holds tvalid (AXI-Stream rules, no drop).
- Widths:
  - Ratio comparisons are unsigned RATE_DW.
  - Timeout counter is RATE_DW+1 bits (holds 2*CIC_R without overflow).
  - SETTLE counter is clog2(CIC_N+1) bits.
- Counters clear on every entry to their state.

Test Plan:
- Reset release with CIC_R=10 and FLUSH_CYCLES=4:
  - cic_reset_n low for 4 clocks after deassert, then one m_axis_rate_tvalid with tdata=10.
  - The first 7 cic_out_tvalid strobes are masked; strobe 8 passes; busy falls as tready rises.
- IDLE, request 5, decimator outputs every 10 inputs:
  - FLUSH starts the cycle after the next cic_out_tvalid.
  - Load strobe carries 5; current_rate=5; 7 outputs masked; then IDLE.
- Out-of-range requests: request 1 → accepted, cfg_error pulses one cycle, current_rate unchanged, no flush. Request 11 → same response.
- Same-rate request: request 10 while current_rate=10 → accepted; no flush, no load, no error; busy stays 0.
- Stalled boundary: in WAIT_BND with current_rate=10, drive 20 cic_in_tvalid and no output → FLUSH entered after strobe 20. A second request held valid during the sequence is accepted only after return to IDLE.
- Reset mid-sequence: assert reset during SETTLE → state INIT immediately (async) with current_rate=10; on release the full INIT sequence repeats with ratio 10.
